// File: rtl/d_reg_pipe.sv
// Stallable, flushable register pipeline with per-stage valid bits and an occupancy count.
// Optional macro D_REG_PIPE_DATA_GATE_EN: stages that receive an invalid slot load RST_VAL instead of data.
module d_reg_pipe #(
  parameter int              WIDTH   = 8,
  parameter int              DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  input  logic                       en,
  input  logic                       flush,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_r     [DEPTH];
  logic [WIDTH-1:0] data_nxt_s [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] valid_nxt_s;
  logic [OCC_W-1:0] occ_r;
  logic [OCC_W-1:0] occ_nxt_s;

  // Next-state: flush clears everything, en shifts, otherwise hold.
  always_comb begin
    data_nxt_s  = data_r;
    valid_nxt_s = valid_r;
    occ_nxt_s   = occ_r;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_nxt_s[i] = RST_VAL;
      end
      valid_nxt_s = '0;
      occ_nxt_s   = '0;
    end else if (en) begin
      valid_nxt_s[0] = d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_nxt_s[i] = valid_r[i-1];
      end
`ifdef D_REG_PIPE_DATA_GATE_EN
      data_nxt_s[0] = d_valid ? d : RST_VAL;
      for (int i = 1; i < DEPTH; i++) begin
        data_nxt_s[i] = valid_r[i-1] ? data_r[i-1] : RST_VAL;
      end
`else
      data_nxt_s[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        data_nxt_s[i] = data_r[i-1];
      end
`endif
      // One slot enters and one leaves per edge, so the count stays within 0..DEPTH.
      occ_nxt_s = occ_r + OCC_W'(d_valid) - OCC_W'(valid_r[DEPTH-1]);
    end else begin
      occ_nxt_s = occ_r;
    end
  end

  // Pipeline state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= RST_VAL;
      end
      valid_r <= '0;
      occ_r   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= data_nxt_s[i];
      end
      valid_r <= valid_nxt_s;
      occ_r   <= occ_nxt_s;
    end
  end

  assign q         = data_r[DEPTH-1];
  assign q_valid   = valid_r[DEPTH-1];
  assign occupancy = occ_r;

endmodule

// File: tb/tb_d_reg_pipe.sv
// Directed bench for d_reg_pipe: a DEPTH=4 instance and a DEPTH=1 instance.
module tb_d_reg_pipe;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic       d_valid;
  logic       en;
  logic       flush;
  logic [7:0] q;
  logic       q_valid;
  logic [2:0] occupancy;

  logic [7:0] d1;
  logic       dv1;
  logic       en1;
  logic       flush1;
  logic [7:0] q1;
  logic       qv1;
  logic [0:0] occ1;

  int n_total = 0;
  int n_bad   = 0;

  d_reg_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .en(en), .flush(flush),
    .q(q), .q_valid(q_valid), .occupancy(occupancy)
  );

  d_reg_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h3C)) dut1 (
    .clk(clk), .rst(rst), .d(d1), .d_valid(dv1), .en(en1), .flush(flush1),
    .q(q1), .q_valid(qv1), .occupancy(occ1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [7:0] eq, input logic eqv, input logic [2:0] eocc);
    check_val({tag, ".q"}, 32'(q), 32'(eq));
    check_val({tag, ".qv"}, 32'(q_valid), 32'(eqv));
    check_val({tag, ".occ"}, 32'(occupancy), 32'(eocc));
  endtask

  initial begin
    rst = 1'b1; d = 8'h00; d_valid = 1'b0; en = 1'b0; flush = 1'b0;
    d1 = 8'hFF; dv1 = 1'b0; en1 = 1'b0; flush1 = 1'b0;
    #1;
    check_main("reset", 8'h00, 1'b0, 3'd0);
    check_val("reset1.q", 32'(q1), 32'h3C);
    step(); step();
    rst = 1'b0;

    // Basic fill and drain, latency 4
    en = 1'b1;
    d = 8'h11; d_valid = 1'b1; step(); check_main("fill1", 8'h00, 1'b0, 3'd1);
    d = 8'h22;                 step(); check_main("fill2", 8'h00, 1'b0, 3'd2);
    d = 8'h33;                 step(); check_main("fill3", 8'h00, 1'b0, 3'd3);
    d = 8'h00; d_valid = 1'b0; step(); check_main("out11", 8'h11, 1'b1, 3'd3);
    step(); check_main("out22", 8'h22, 1'b1, 3'd2);
    step(); check_main("out33", 8'h33, 1'b1, 3'd1);
    step(); check_val("drain.qv", 32'(q_valid), 32'h0);
    check_val("drain.occ", 32'(occupancy), 32'h0);

    // Stall with A5 in stage 2
    d = 8'hA5; d_valid = 1'b1; step();
    d = 8'h00; d_valid = 1'b0; step(); step();
    check_main("a5_pos", 8'h00, 1'b0, 3'd1);
    en = 1'b0; d = 8'hFF; d_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); check_main("stall", 8'h00, 1'b0, 3'd1);
    end
    en = 1'b1; d = 8'h00; d_valid = 1'b0;
    step(); check_main("a5_out", 8'hA5, 1'b1, 3'd1);
    step(); check_main("a5_gone", 8'h00, 1'b0, 3'd0);

    // Full pipe with continuous input, then flush
    for (int i = 1; i <= 4; i++) begin
      d = 8'(i); d_valid = 1'b1; step();
    end
    check_main("full", 8'h01, 1'b1, 3'd4);
    d = 8'h05; step(); check_main("full_a", 8'h02, 1'b1, 3'd4);
    d = 8'h06; step(); check_main("full_b", 8'h03, 1'b1, 3'd4);
    flush = 1'b1; d = 8'h77; step(); check_main("flush", 8'h00, 1'b0, 3'd0);
    flush = 1'b0; d_valid = 1'b0; d = 8'h00; step(); check_main("post_flush", 8'h00, 1'b0, 3'd0);

    // Asynchronous reset between edges with occupancy 3
    for (int i = 0; i < 4; i++) begin
      d = 8'h0A + 8'(i); d_valid = 1'b1; step();
    end
    d_valid = 1'b0; d = 8'h00; step();
    check_main("pre_rst", 8'h0B, 1'b1, 3'd3);
    #2 rst = 1'b1;
    #1 check_main("async_rst", 8'h00, 1'b0, 3'd0);
    #1 rst = 1'b0;
    d = 8'h5C; d_valid = 1'b1; step(); check_main("rst_load", 8'h00, 1'b0, 3'd1);
    d = 8'h00; d_valid = 1'b0; step(); step(); step();
    check_main("rst_out", 8'h5C, 1'b1, 3'd1);

    // DEPTH=1: alternating valid
    en1 = 1'b1; d1 = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      dv1 = (i % 2 == 0);
      step();
      check_val("d1.qv", 32'(qv1), 32'(dv1));
      check_val("d1.occ", 32'(occ1), 32'(dv1));
      if (qv1) begin
        check_val("d1.q", 32'(q1), 32'hFF);
      end else begin
`ifdef D_REG_PIPE_DATA_GATE_EN
        check_val("d1.qgate", 32'(q1), 32'h3C);
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/d_reg_pipe.md
D_REG_PIPE -- requirements
Module: d_reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per stage (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 SHALL have parameter RST_VAL, default 0, WIDTH-bit value loaded into data stages on reset/flush.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port d, input, WIDTH, data into stage 0.
REQ-007 SHALL have port d_valid, input, 1, marks d as valid.
REQ-008 SHALL have port en, input, 1, advance enable; 0 = whole pipe stalls.
REQ-009 SHALL have port flush, input, 1, synchronous clear of all valid bits.
REQ-010 SHALL have port q, output, WIDTH, registered data of stage DEPTH-1.
REQ-011 SHALL have port q_valid, output, 1, registered valid of stage DEPTH-1.
REQ-012 SHALL have port occupancy, output, $clog2(DEPTH+1), registered count of valid stages.

Function
REQ-013 SHALL, on edge with en=1 and flush=0: stage0 <= {d, d_valid}; stage i <= stage i-1 for i=1..DEPTH-1.
REQ-014 SHALL hold every stage (data, valid) and occupancy unchanged on edge with en=0 and flush=0.
REQ-015 SHALL give latency DEPTH enabled edges from d/d_valid sampled to q/q_valid; stalled cycles add no data loss.
REQ-016 SHALL, on edge with flush=1, clear all valid bits, load all data stages with RST_VAL, set occupancy 0; flush has priority over en and discards d.
REQ-017 SHALL update occupancy on enabled edge as occupancy + d_valid - q_valid (pre-edge values); never exceeds DEPTH, never underflows.
REQ-018 SHALL, for DEPTH=1, behave as a single enabled register: q/q_valid follow d/d_valid one enabled edge later.
REQ-019 SHALL drive q and q_valid directly from flops; no combinational path from any input to any output.
REQ-020 SHALL keep occupancy equal to popcount of stage valid bits at every edge.

Reset
REQ-021 SHALL, while rst=1, asynchronously force all data stages to RST_VAL, all valid bits 0, occupancy 0, independent of clk.
REQ-022 SHALL, on rst assertion mid-operation, discard all in-flight data; first enabled edge after deassertion loads stage 0 normally.
REQ-023 SHALL give rst priority over flush and en.

Configuration
REQ-024 SHALL, with macro D_REG_PIPE_DATA_GATE_EN defined, load a data stage only when its incoming valid is 1; stage receiving valid=0 on an enabled edge loads RST_VAL, so q=RST_VAL whenever q_valid=0.
REQ-025 SHALL, without D_REG_PIPE_DATA_GATE_EN, shift data unconditionally on enabled edges regardless of valid; q content when q_valid=0 is don't-care.

Verification
REQ-026 SHALL cover: WIDTH=8, DEPTH=4, en=1, d=0x11,0x22,0x33 with d_valid=1 -> q=0x11 with q_valid=1 on 4th edge, then 0x22, 0x33; occupancy 1,2,3,3.
REQ-027 SHALL cover: pipe holding 0xA5 in stage 2, en=0 for 5 cycles -> q, q_valid, occupancy unchanged; after en=1, 0xA5 appears at q after 1 more edge.
REQ-028 SHALL cover: occupancy=4, flush=1 with en=1, d_valid=1 -> next edge q_valid=0, occupancy=0, q=RST_VAL.
REQ-029 SHALL cover: occupancy=3, rst pulsed between clock edges -> q_valid=0, occupancy=0, q=RST_VAL immediately, before next edge.
REQ-030 SHALL cover: DEPTH=1, alternating d_valid=1/0 with d=0xFF -> q_valid toggles one edge later; with D_REG_PIPE_DATA_GATE_EN, q=RST_VAL on each q_valid=0 cycle.
REQ-031 SHALL cover: full pipe (occupancy=DEPTH) with d_valid=1 continuously -> occupancy stays DEPTH, no overflow.
